// File: rtl/wd_order_ctrl_if.sv
// wd_order_ctrl_if
// Bundles the AW grant, W beat and status signals of the write-data ordering
// controller.
//   slave modport  : the controller itself (wd_order_ctrl).
//   master modport : the surrounding interconnect (AW arbiter, W mux, slave).
// Parameter DEPTH must match the DEPTH of the attached wd_order_ctrl.
interface wd_order_ctrl_if #(
   parameter int DEPTH = 4
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic             AW_grant_valid;
   logic             AW_grant_master;
   logic [7:0]       AW_grant_len;
   logic             AW_full;
   logic             Sel_S_AXI_wvalid;
   logic             Sel_S_AXI_wlast;
   logic             M_AXI_wvalid;
   logic             M_AXI_wready;
   logic             S00_AXI_wready;
   logic             S01_AXI_wready;
   logic [1:0]       Selected_Slave;
   logic [CNT_W-1:0] Occupancy;
   logic             Wd_ovf_err;
   logic             Wd_last_err;

   modport slave (
      input  AW_grant_valid, AW_grant_master, AW_grant_len,
      input  Sel_S_AXI_wvalid, Sel_S_AXI_wlast, M_AXI_wready,
      output AW_full, M_AXI_wvalid, S00_AXI_wready, S01_AXI_wready,
      output Selected_Slave, Occupancy, Wd_ovf_err, Wd_last_err
   );

   modport master (
      output AW_grant_valid, AW_grant_master, AW_grant_len,
      output Sel_S_AXI_wvalid, Sel_S_AXI_wlast, M_AXI_wready,
      input  AW_full, M_AXI_wvalid, S00_AXI_wready, S01_AXI_wready,
      input  Selected_Slave, Occupancy, Wd_ovf_err, Wd_last_err
   );
endinterface

// File: rtl/wd_order_ctrl.sv
// wd_order_ctrl
// Write-data ordering controller for a 2-master AXI4 write path. Queues the
// masters granted by the AW arbiter and releases W bursts in that same order:
// drives the W mux select, gates wvalid toward the slave and steers wready
// back to the owning master. The head entry retires on the last beat.
// Ports:
//   ACLK   : clock, rising edge
//   ARESET : synchronous active-high reset
//   bus    : wd_order_ctrl_if.slave (grant input, W handshake, status)
// Optional feature macro WD_LAST_CHECK_EN: stores AWLEN per grant, counts
// beats to find the last beat and flags wlast mismatches in Wd_last_err.
// Without it the last beat is taken from Sel_S_AXI_wlast.
module wd_order_ctrl #(
   parameter int DEPTH = 4
) (
   input  logic          ACLK,
   input  logic          ARESET,
   wd_order_ctrl_if.slave bus
);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = $clog2(DEPTH);

   logic [DEPTH-1:0] mst_mem;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;
   logic             last_master;
   logic             ovf_err;

   logic nonempty;
   logic full;
   logic head_master;
   logic sel_master;
   logic hs;
   logic last_beat;
   logic push;
   logic pop;

   assign nonempty    = (count != '0);
   assign full        = (count == CNT_W'(DEPTH));
   assign head_master = mst_mem[rd_ptr];
   // With the queue empty the mux keeps pointing at the last retired master.
   assign sel_master  = nonempty ? head_master : last_master;

   assign hs   = bus.Sel_S_AXI_wvalid & nonempty & bus.M_AXI_wready;
   // Full is taken from the registered count, so a same-cycle pop never
   // makes room for a push.
   assign push = bus.AW_grant_valid & ~full;
   assign pop  = hs & last_beat;

   assign bus.AW_full        = full;
   assign bus.M_AXI_wvalid   = bus.Sel_S_AXI_wvalid & nonempty;
   assign bus.S00_AXI_wready = bus.M_AXI_wready & nonempty & ~head_master;
   assign bus.S01_AXI_wready = bus.M_AXI_wready & nonempty &  head_master;
   assign bus.Selected_Slave = {1'b0, sel_master};
   assign bus.Occupancy      = count;
   assign bus.Wd_ovf_err     = ovf_err;

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         mst_mem     <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         last_master <= 1'b0;
         ovf_err     <= 1'b0;
      end else begin
         if (push) begin
            mst_mem[wr_ptr] <= bus.AW_grant_master;
            wr_ptr          <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr      <= rd_ptr + PTR_W'(1);
            last_master <= head_master;
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         if (bus.AW_grant_valid && full)
            ovf_err <= 1'b1;
      end
   end

`ifdef WD_LAST_CHECK_EN
   logic [7:0] len_mem [DEPTH];
   logic [7:0] beat_cnt;
   logic [7:0] head_len;
   logic       last_err;

   assign head_len  = len_mem[rd_ptr];
   assign last_beat = (beat_cnt == head_len);
   assign bus.Wd_last_err = last_err;

   always_ff @(posedge ACLK) begin
      if (push)
         len_mem[wr_ptr] <= bus.AW_grant_len;
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         beat_cnt <= 8'd0;
         last_err <= 1'b0;
      end else begin
         if (pop)
            beat_cnt <= 8'd0;
         else if (hs)
            beat_cnt <= beat_cnt + 8'd1;
         if (hs && (bus.Sel_S_AXI_wlast != last_beat))
            last_err <= 1'b1;
      end
   end
`else
   logic unused_len;

   assign unused_len      = ^bus.AW_grant_len;
   assign last_beat       = bus.Sel_S_AXI_wlast;
   assign bus.Wd_last_err = 1'b0;
`endif
endmodule

// File: tb/tb_wd_order_ctrl.sv
module tb_wd_order_ctrl;
   localparam int DEPTH = 4;

   logic ACLK = 1'b0;
   logic ARESET = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 ACLK = ~ACLK;

   wd_order_ctrl_if #(.DEPTH(DEPTH)) bus ();

   wd_order_ctrl #(.DEPTH(DEPTH)) dut (
      .ACLK   (ACLK),
      .ARESET (ARESET),
      .bus    (bus)
   );

   // Reference model: queue of outstanding grants in AW-grant order.
   typedef struct packed {
      logic       m;
      logic [7:0] len;
   } grant_t;

   grant_t     q[$];
   logic       m_last_m = 1'b0;
   int         m_beat   = 0;
   logic       m_ovf    = 1'b0;
   logic       m_lerr   = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic gv, input logic gm, input logic [7:0] gl,
                        input logic wv, input logic wl, input logic wr);
      bus.AW_grant_valid   = gv;
      bus.AW_grant_master  = gm;
      bus.AW_grant_len     = gl;
      bus.Sel_S_AXI_wvalid = wv;
      bus.Sel_S_AXI_wlast  = wl;
      bus.M_AXI_wready     = wr;
   endtask

   function automatic logic model_last();
`ifdef WD_LAST_CHECK_EN
      return (m_beat == int'(q[0].len));
`else
      return bus.Sel_S_AXI_wlast;
`endif
   endfunction

   // Compare outputs mid-cycle, then advance the model across the clock edge.
   task automatic step();
      logic ne, hd, hs, lst, full;
      #4;
      ne = (q.size() != 0);
      hd = ne ? q[0].m : m_last_m;
      chk("occupancy",  32'(bus.Occupancy), 32'(q.size()));
      chk("aw_full",    32'(bus.AW_full), 32'(q.size() == DEPTH));
      chk("sel_slave",  32'(bus.Selected_Slave), {31'd0, hd});
      chk("m_wvalid",   32'(bus.M_AXI_wvalid), 32'(bus.Sel_S_AXI_wvalid && ne));
      chk("s00_wready", 32'(bus.S00_AXI_wready), 32'(bus.M_AXI_wready && ne && hd == 1'b0));
      chk("s01_wready", 32'(bus.S01_AXI_wready), 32'(bus.M_AXI_wready && ne && hd == 1'b1));
      chk("ovf_err",    32'(bus.Wd_ovf_err), 32'(m_ovf));
      chk("last_err",   32'(bus.Wd_last_err), 32'(m_lerr));
      @(posedge ACLK);
      if (ARESET) begin
         q.delete();
         m_last_m = 1'b0;
         m_beat   = 0;
         m_ovf    = 1'b0;
         m_lerr   = 1'b0;
      end else begin
         full = (q.size() == DEPTH);
         hs   = bus.Sel_S_AXI_wvalid && bus.M_AXI_wready && ne;
         lst  = ne ? model_last() : 1'b0;
`ifdef WD_LAST_CHECK_EN
         if (hs && (bus.Sel_S_AXI_wlast != lst)) m_lerr = 1'b1;
`endif
         if (bus.AW_grant_valid && full) m_ovf = 1'b1;
         if (hs && lst) begin
            m_last_m = q[0].m;
            void'(q.pop_front());
            m_beat = 0;
         end else if (hs) begin
            m_beat++;
         end
         if (bus.AW_grant_valid && !full)
            q.push_back('{m: bus.AW_grant_master, len: bus.AW_grant_len});
      end
      #1;
   endtask

   initial begin
      logic [1:0] wr_pat [4];

      drive(0, 0, 8'd0, 1, 0, 1);
      ARESET = 1'b1;
      @(posedge ACLK);
      @(posedge ACLK);
      #1;

      // Reset/idle: two checked reset cycles with wvalid high
      step();
      step();
      ARESET = 1'b0;
      step();

      // Order preservation: M1 (len 3) then M0 (len 1)
      drive(1, 1, 8'd3, 0, 0, 0); step();
      drive(1, 0, 8'd1, 0, 0, 0); step();
      drive(0, 0, 8'd0, 1, 0, 1); step();
      step();
      step();
      drive(0, 0, 8'd0, 1, 1, 1); step();
      drive(0, 0, 8'd0, 1, 0, 1); step();
      drive(0, 0, 8'd0, 1, 1, 1); step();
      drive(0, 0, 8'd0, 0, 0, 0); step();

      // Backpressure: wready 1,0,0,1 during a 2-beat M0 burst
      wr_pat = '{2'd1, 2'd0, 2'd0, 2'd1};
      drive(1, 0, 8'd1, 0, 0, 0); step();
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 8'd0, 1, (i != 0), wr_pat[i][0]);
         step();
      end
      drive(0, 0, 8'd0, 0, 0, 0); step();

      // Full / overflow, then pop at full with a concurrent grant
      for (int i = 0; i < 5; i++) begin
         drive(1, i[0], 8'd0, 0, 0, 0);
         step();
      end
      drive(1, 1, 8'd0, 1, 1, 1); step();
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 8'd0, 1, 1, 1);
         step();
      end
      drive(0, 0, 8'd0, 0, 0, 0); step();

      // Wrap-around: alternating single-beat bursts, push and pop interleaved
      for (int i = 0; i < 12; i++) begin
         drive((i < 10), i[0], 8'd0, 1, 1, 1);
         step();
      end
      drive(0, 0, 8'd0, 0, 0, 0); step();

      // Last-beat check: len 2, wlast on beat 2
      drive(1, 0, 8'd2, 0, 0, 0); step();
      drive(0, 0, 8'd0, 1, 0, 1); step();
      drive(0, 0, 8'd0, 1, 1, 1); step();
      drive(0, 0, 8'd0, 1, 0, 1); step();
      drive(0, 0, 8'd0, 0, 0, 0); step();

      // Randomized traffic with a mid-run reset
      for (int i = 0; i < 400; i++) begin
         ARESET = (i == 200);
`ifdef WD_LAST_CHECK_EN
         drive(($urandom_range(2) == 0), 1'($urandom), 8'($urandom_range(3)),
               1'($urandom), 1'($urandom), 1'($urandom));
         if (q.size() != 0)
            bus.Sel_S_AXI_wlast = (m_beat == int'(q[0].len));
`else
         drive(($urandom_range(2) == 0), 1'($urandom), 8'($urandom_range(3)),
               1'($urandom), ($urandom_range(2) == 0), 1'($urandom));
`endif
         step();
      end
      ARESET = 1'b0;
      drive(0, 0, 8'd0, 0, 0, 0);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
